// File: rtl/mux_pkg.sv
// Shared definitions for the TDM scan multiplexer.
// Provides the mode encodings and a constant clog2 used to size channel indices.
// No ports; imported by tdm_scan_mux and scan_ctrl.
package mux_pkg;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  // Index width for n channels; at least 1 bit so a 1-wide select still exists.
  function automatic int clog2(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/tdm_scan_mux_scan_ctrl.sv
// Channel pointer for the TDM scan mux: follows sel in manual mode, round-robins in scan mode.
// Ports: mode/sel/dwell controls, per-channel valids and the output-load strobe in;
//        current channel index and a one-cycle wrap pulse out.
module scan_ctrl
  import mux_pkg::*;
#(
  parameter int N_CH    = 4,
  parameter int DWELL_W = 8,
  parameter int SEL_W   = clog2(N_CH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mode_i,
  input  logic [SEL_W-1:0]   sel_i,
  input  logic [DWELL_W-1:0] dwell_i,
  input  logic [N_CH-1:0]    in_valid_i,
  input  logic               load_i,
  output logic [SEL_W-1:0]   cur_ch_o,
  output logic               scan_wrap_o
);

  localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(N_CH - 1);

  logic [SEL_W-1:0]   cur_ch_q,   cur_ch_d;
  logic [DWELL_W-1:0] beat_cnt_q, beat_cnt_d;
  logic               wrap_q,     wrap_d;
  logic               advance;

  // An empty channel is skipped immediately so it costs one idle cycle and no beats.
  // Using >= lets a mid-dwell reduction of dwell take effect on the next load.
  assign advance = (load_i && (beat_cnt_q >= dwell_i)) || !in_valid_i[cur_ch_q];

  always_comb begin
    cur_ch_d   = cur_ch_q;
    beat_cnt_d = beat_cnt_q;
    wrap_d     = 1'b0;
    if (mode_i == MODE_MANUAL) begin
      beat_cnt_d = '0;
      // Out-of-range selects are ignored rather than wrapped.
      if (int'(sel_i) < N_CH) cur_ch_d = sel_i;
    end else if (advance) begin
      beat_cnt_d = '0;
      if (cur_ch_q == LAST_CH) begin
        cur_ch_d = '0;
        wrap_d   = 1'b1;
      end else begin
        cur_ch_d = cur_ch_q + 1'b1;
      end
    end else if (load_i) begin
      beat_cnt_d = beat_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_ch_q   <= '0;
      beat_cnt_q <= '0;
      wrap_q     <= 1'b0;
    end else begin
      cur_ch_q   <= cur_ch_d;
      beat_cnt_q <= beat_cnt_d;
      wrap_q     <= wrap_d;
    end
  end

  assign cur_ch_o    = cur_ch_q;
  assign scan_wrap_o = wrap_q;

endmodule

// File: rtl/tdm_scan_mux.sv
// N-channel W-bit multiplexer with a registered, valid/ready output; manual or scanning select.
// Ports: in_data/in_valid per channel, mode/sel/dwell controls; out_data/out_ch/out_valid with
//        out_ready backpressure (word held stable while stalled), scan_wrap pulse. Latency 1 cycle.
module tdm_scan_mux
  import mux_pkg::*;
#(
  parameter  int N_CH    = 4,
  parameter  int W       = 8,
  parameter  int DWELL_W = 8,
  localparam int SEL_W   = clog2(N_CH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_CH*W-1:0]   in_data,
  input  logic [N_CH-1:0]     in_valid,
  input  logic                mode,
  input  logic [SEL_W-1:0]    sel,
  input  logic [DWELL_W-1:0]  dwell,
  output logic [W-1:0]        out_data,
  output logic [SEL_W-1:0]    out_ch,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                scan_wrap
);

  logic [SEL_W-1:0] cur_ch;
  logic             load;
  logic [W-1:0]     out_data_q, out_data_d;
  logic [SEL_W-1:0] out_ch_q,   out_ch_d;
  logic             out_vld_q,  out_vld_d;

  // Accept a new word when the current channel has one and the register is free or draining.
  assign load = in_valid[cur_ch] && (!out_vld_q || out_ready);

  scan_ctrl #(
    .N_CH    (N_CH),
    .DWELL_W (DWELL_W),
    .SEL_W   (SEL_W)
  ) u_scan_ctrl (
    .clk         (clk),
    .rst         (rst),
    .mode_i      (mode),
    .sel_i       (sel),
    .dwell_i     (dwell),
    .in_valid_i  (in_valid),
    .load_i      (load),
    .cur_ch_o    (cur_ch),
    .scan_wrap_o (scan_wrap)
  );

  always_comb begin
    out_data_d = out_data_q;
    out_ch_d   = out_ch_q;
    out_vld_d  = out_vld_q;
    if (load) begin
      out_data_d = in_data[int'(cur_ch)*W +: W];
      out_ch_d   = cur_ch;
      out_vld_d  = 1'b1;
    end else if (out_ready) begin
      out_vld_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data_q <= '0;
      out_ch_q   <= '0;
      out_vld_q  <= 1'b0;
    end else begin
      out_data_q <= out_data_d;
      out_ch_q   <= out_ch_d;
      out_vld_q  <= out_vld_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
  assign out_valid = out_vld_q;

endmodule
